// File: rtl/fifo_rd_burst_ctrl.sv
// fifo_rd_burst_ctrl: read-side burst sequencer for asyn_fifo (rd_clk domain).
// Latency: first m_valid 2 cycles after a burst starts, then 1 word/cycle with m_ready=1.
// Backpressure: m_ready low holds the 2-entry output buffer; pops stop while it cannot absorb.
// Optional feature macro FIFO_RD_FLUSH_EN: idle timeout drains residual words as 1-word bursts.
module fifo_rd_burst_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_LEN      = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  burst_cnt
);

  localparam int IW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic [IW-1:0]         issued_q;
  logic [IW-1:0]         len_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  // Output buffer: entry 0 is the head and drives m_data/m_last directly.
  logic                  vld0_q, vld1_q;
  logic [DATA_WIDTH-1:0] dat0_q, dat1_q;
  logic                  last0_q, last1_q;
  logic [CNT_WIDTH-1:0]  burst_cnt_q;

  logic                  pop;
  logic                  push;
  logic [1:0]            occ_after_pop;
  logic                  start_full;
  logic                  start_flush;

  assign pop  = vld0_q && m_ready;
  assign push = inflight_q;

  // Room is judged after this cycle's pop so a steady m_ready=1 stream pops every cycle.
  assign occ_after_pop = {1'b0, vld0_q} + {1'b0, vld1_q} - {1'b0, pop};
  assign fifo_rd_en    = (state_q == BURST) && !fifo_empty &&
                         ((occ_after_pop + {1'b0, inflight_q}) < 2'd2) &&
                         (issued_q < len_q);

  assign start_full = enable && !fifo_almost_empty;

`ifdef FIFO_RD_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_q;
  logic          flush_cond;

  assign flush_cond  = enable && !fifo_empty && fifo_almost_empty;
  assign start_flush = flush_cond && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle cycles with residual data; any break or leaving IDLE clears it.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q == IDLE) && flush_cond && !start_flush) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  assign start_flush = 1'b0;
`endif

  // Burst FSM: start on threshold (or flush timeout), issue len_q pops, wait for last accept.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      issued_q <= '0;
      len_q    <= IW'(BURST_LEN);
    end else begin
      case (state_q)
        IDLE: begin
          issued_q <= '0;
          if (start_full) begin
            state_q <= BURST;
            busy_q  <= 1'b1;
            len_q   <= IW'(BURST_LEN);
          end else if (start_flush) begin
            state_q <= BURST;
            busy_q  <= 1'b1;
            len_q   <= IW'(1);
          end
        end
        BURST: begin
          if (fifo_rd_en) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q == len_q - 1'b1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last0_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Track the pop issued last cycle and whether it is the final word of the burst.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (fifo_rd_en) inflight_last_q <= (issued_q == len_q - 1'b1);
    end
  end

  // Two-entry in-order buffer: landing words go to the tail, the head shifts on accept.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!vld0_q) begin
            vld0_q  <= 1'b1;
            dat0_q  <= fifo_rd_data;
            last0_q <= inflight_last_q;
          end else begin
            vld1_q  <= 1'b1;
            dat1_q  <= fifo_rd_data;
            last1_q <= inflight_last_q;
          end
        end
        2'b01: begin
          vld0_q <= vld1_q;
          vld1_q <= 1'b0;
          if (vld1_q) begin
            dat0_q  <= dat1_q;
            last0_q <= last1_q;
          end
        end
        2'b11: begin
          if (vld1_q) begin
            dat0_q  <= dat1_q;
            last0_q <= last1_q;
            dat1_q  <= fifo_rd_data;
            last1_q <= inflight_last_q;
          end else begin
            dat0_q  <= fifo_rd_data;
            last0_q <= inflight_last_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completed-burst counter, free-running with wrap.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      burst_cnt_q <= '0;
    end else if (pop && last0_q) begin
      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end

  assign m_valid   = vld0_q;
  assign m_data    = dat0_q;
  assign m_last    = last0_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Bench for fifo_rd_burst_ctrl: behavioural FIFO feeding the DUT, stream-level reference model.
// Expected output = write order; last on every 4th accepted word; burst_cnt = accepted/4.
// Directed scenarios followed by a randomized phase with random writes, enable and m_ready.
module tb_fifo_rd_burst_ctrl;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int GAP = 3;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_cnt;

  fifo_rd_burst_ctrl #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];      // FIFO contents
  logic [DW-1:0] exp_q[$];  // words still owed on the output stream
  int            rd_log[$];
  int            cyc = 0, pop_cnt = 0, acc_cnt = 0, out_cnt = 0, lasts_seen = 0;
  int            vld_cnt = 0, first_vld = -1;
  logic          hold_q = 1'b0, hold_last = 1'b0, after_last = 1'b0;
  logic [DW-1:0] hold_dat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    q.push_back(d);
    exp_q.push_back(d);
  endtask

  // One clock: drive FIFO flags and m_ready, check the stream, model the FIFO pop.
  task automatic cycle(input logic rdy);
    logic rd, acc;
    logic [DW-1:0] w, e;
    int outst;
    w = '0;
    fifo_empty        = (q.size() == 0);
    fifo_almost_empty = (q.size() <= GAP);
    m_ready           = rdy;
    #1;
    rd  = fifo_rd_en;
    acc = m_valid && m_ready;
    chk("no_underflow", rd && fifo_empty, 0);
    if (hold_q) begin
      chk("hold_vld", m_valid, 1);
      chk("hold_dat", m_data, hold_dat);
      chk("hold_last", m_last, hold_last);
    end
    if (m_valid || rd) chk("busy_active", busy, 1);
    if (after_last) chk("busy_fall", busy, 0);
    if (rd) begin
      outst = pop_cnt - acc_cnt - (acc ? 1 : 0);
      chk("buf_capacity", outst < 2, 1);
    end
`ifdef FIFO_RD_FLUSH_EN
    chk("burst_cnt", burst_cnt, lasts_seen);
`else
    chk("burst_cnt", burst_cnt, acc_cnt / BL);
`endif
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid) vld_cnt++;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", m_data, e);
      end
`ifndef FIFO_RD_FLUSH_EN
      chk("last", m_last, (acc_cnt % BL) == BL - 1);
`endif
      acc_cnt++;
      out_cnt++;
      if (m_last) lasts_seen++;
    end
    after_last = acc && m_last;
    hold_q     = m_valid && !m_ready;
    hold_dat   = m_data;
    hold_last  = m_last;
    if (rd) begin
      pop_cnt++;
      rd_log.push_back(cyc);
      if (q.size() > 0) w = q.pop_front();
    end
    cyc++;
    @(posedge rd_clk);
    #1;
    if (rd) fifo_rd_data = w;
    @(negedge rd_clk);
  endtask

  function automatic bit idle_done();
`ifdef FIFO_RD_FLUSH_EN
    return !busy && !m_valid && (exp_q.size() == q.size()) && (q.size() == 0);
`else
    return !busy && !m_valid && (exp_q.size() == q.size()) && (q.size() <= GAP);
`endif
  endfunction

  // mode 0: ready always, 1: toggling, 2: random
  task automatic drain(input int mode, input int budget);
    int n;
    logic r;
    n = 0;
    do begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      cycle(r);
      n++;
    end while (!idle_done() && n < budget);
    chk("drain_done", idle_done(), 1);
  endtask

  task automatic model_reset();
    exp_q = q;
    pop_cnt = 0; acc_cnt = 0; lasts_seen = 0;
    hold_q = 1'b0; after_last = 1'b0;
  endtask

  initial begin
    int k, p0, l0, o0, a0, n;
    logic [DW-1:0] s0, s1;
    rd_rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    fifo_empty = 1'b1; fifo_almost_empty = 1'b1; fifo_rd_data = '0;
    #12;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", burst_cnt, 0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    repeat (3) cycle(1);

    // 1: single burst at full rate
    for (int i = 1; i <= 4; i++) wr(16'(i));
    rd_log.delete(); first_vld = -1; k = cyc;
    repeat (10) cycle(1);
    chk("t1_pops", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t1_pop_cycle", rd_log[i], k + 1 + i);
    chk("t1_first_vld", first_vld, k + 3);
    chk("t1_bursts", burst_cnt, 1);
    chk("t1_busy", busy, 0);

    // 2: two bursts with m_ready toggling
    o0 = out_cnt; l0 = lasts_seen;
    for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i));
    drain(1, 200);
    chk("t2_words", out_cnt - o0, 8);
    chk("t2_lasts", lasts_seen - l0, 2);
    chk("t2_bursts", burst_cnt, 3);

    // 3: residual data below threshold
    p0 = pop_cnt; l0 = lasts_seen; vld_cnt = 0;
    for (int i = 0; i < 3; i++) wr(16'h0200 + 16'(i));
`ifdef FIFO_RD_FLUSH_EN
    repeat (80) cycle(1);
    chk("t3_flush_pops", pop_cnt - p0, 3);
    chk("t3_flush_lasts", lasts_seen - l0, 3);
`else
    repeat (40) cycle(1);
    chk("t3_no_pops", pop_cnt - p0, 0);
    chk("t3_no_valid", vld_cnt, 0);
    wr(16'h0203);
    drain(0, 100);
    chk("t3_refill_lasts", lasts_seen - l0, 1);
`endif

    // 4: FIFO runs dry mid-burst, refill later
    for (int i = 0; i < 4; i++) wr(16'h0300 + 16'(i));
    l0 = lasts_seen;
    cycle(1);
    s1 = q.pop_back(); s0 = q.pop_back();
    p0 = pop_cnt;
    repeat (10) cycle(1);
    chk("t4_stall_pops", pop_cnt - p0, 2);
    chk("t4_busy_stall", busy, 1);
    q.push_back(s0); q.push_back(s1);
    drain(0, 100);
    chk("t4_lasts", lasts_seen - l0, 1);

    // 5: reset mid-burst after second accepted word
    for (int i = 0; i < 4; i++) wr(16'h0400 + 16'(i));
    a0 = acc_cnt; n = 0;
    while (acc_cnt - a0 < 2 && n < 50) begin cycle(1); n++; end
    chk("t5_reach", acc_cnt - a0, 2);
    #2 rd_rst_n = 1'b0;
    #1;
    chk("t5_rd_en", fifo_rd_en, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    chk("t5_last", m_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", burst_cnt, 0);
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) wr(16'h0500 + 16'(i));
    drain(0, 100);
    chk("t5_fresh_cnt", burst_cnt, 1);

    // 6: enable low blocks starts; dropping it mid-burst finishes the burst only
    enable = 1'b0;
    for (int i = 0; i < 8; i++) wr(16'h0600 + 16'(i));
    p0 = pop_cnt;
    repeat (20) cycle(1);
    chk("t6_disabled_pops", pop_cnt - p0, 0);
    enable = 1'b1; l0 = lasts_seen;
    cycle(1);
    enable = 1'b0;
    repeat (30) cycle(1);
    chk("t6_one_burst_pops", pop_cnt - p0, 4);
    chk("t6_left_in_fifo", q.size(), 4);
    chk("t6_lasts", lasts_seen - l0, 1);
    enable = 1'b1;
    drain(0, 100);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) wr(16'($urandom));
      enable = ($urandom_range(0, 7) != 0);
      cycle($urandom_range(0, 3) != 0);
    end
    enable = 1'b1;
    drain(2, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
